// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: 2-entry skid buffer with valid/ready handshake and forwarding view.
// Optional EX_MEM_STALL_CNT_EN adds free-running stall_cnt / xfer_cnt performance counters.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              fwd_wreg,
  output logic [ADDR_W-1:0] fwd_wd,
  output logic [DATA_W-1:0] fwd_wdata
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       xfer_cnt
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_wd_q, out_wd_d;
  logic              out_wreg_q, out_wreg_d;
  logic [DATA_W-1:0] out_wdata_q, out_wdata_d;

  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_wd_q, skid_wd_d;
  logic              skid_wreg_q, skid_wreg_d;
  logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;

  logic accept;
  logic pop;

  // Ready depends only on registered state, never on mem_ready.
  assign ex_ready = !skid_valid_q;
  assign accept   = ex_valid & ex_ready;
  assign pop      = out_valid_q & mem_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_wd_d     = out_wd_q;
    out_wreg_d   = out_wreg_q;
    out_wdata_d  = out_wdata_q;
    skid_valid_d = skid_valid_q;
    skid_wd_d    = skid_wd_q;
    skid_wreg_d  = skid_wreg_q;
    skid_wdata_d = skid_wdata_q;

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_wd_d     = skid_wd_q;
        out_wreg_d   = skid_wreg_q;
        out_wdata_d  = skid_wdata_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_wd_d    = ex_wd;
          skid_wreg_d  = ex_wreg;
          skid_wdata_d = ex_wdata;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_wd_d    = ex_wd;
          out_wreg_d  = ex_wreg;
          out_wdata_d = ex_wdata;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_wd_d    = ex_wd;
      skid_wreg_d  = ex_wreg;
      skid_wdata_d = ex_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      out_valid_q  <= 1'b0;
      out_wd_q     <= '0;
      out_wreg_q   <= 1'b0;
      out_wdata_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_wd_q    <= '0;
      skid_wreg_q  <= 1'b0;
      skid_wdata_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_wd_q     <= out_wd_d;
      out_wreg_q   <= out_wreg_d;
      out_wdata_q  <= out_wdata_d;
      skid_valid_q <= skid_valid_d;
      skid_wd_q    <= skid_wd_d;
      skid_wreg_q  <= skid_wreg_d;
      skid_wdata_q <= skid_wdata_d;
    end
  end

  // Fields are zero-gated so stale register contents never leak downstream.
  assign mem_valid = out_valid_q;
  assign mem_wd    = out_valid_q ? out_wd_q    : '0;
  assign mem_wreg  = out_valid_q ? out_wreg_q  : 1'b0;
  assign mem_wdata = out_valid_q ? out_wdata_q : '0;

  assign fwd_wreg  = mem_valid & mem_wreg;
  assign fwd_wd    = mem_wd;
  assign fwd_wdata = mem_wdata;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid_q && !mem_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (pop)                       xfer_cnt_d  = xfer_cnt_q + 32'd1;
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed plan steps plus random traffic against a queue model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, ex_valid, ex_ready, ex_wreg, mem_valid, mem_ready;
  logic        mem_wreg, fwd_wreg;
  logic [4:0]  ex_wd, mem_wd, fwd_wd;
  logic [31:0] ex_wdata, mem_wdata, fwd_wdata;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt, xfer_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
  } ent_t;

  // Model: the stage is a FIFO of depth 2; ready whenever it holds fewer than two results.
  ent_t q[$];
  logic [31:0] m_stall, m_xfer;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] d,
                      input logic mr, input logic rn, input logic fl);
    bit acc, pp, stl;
    ent_t e;
    resetn = rn; flush = fl; ex_valid = v; ex_wd = wd; ex_wreg = wreg; ex_wdata = d; mem_ready = mr;
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && mr;
    stl = (q.size() > 0) && !mr;
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete(); m_stall = 0; m_xfer = 0;
    end else begin
      if (stl) m_stall = m_stall + 1;
      if (pp)  m_xfer  = m_xfer + 1;
      if (fl) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          e.wd = wd; e.wreg = wreg; e.data = d;
          q.push_back(e);
        end
      end
    end
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e.wd = 0; e.wreg = 0; e.data = 0;
    end
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() > 0});
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, q.size() < 2});
    chk("mem_wd", {27'd0, mem_wd}, {27'd0, e.wd});
    chk("mem_wreg", {31'd0, mem_wreg}, {31'd0, e.wreg});
    chk("mem_wdata", mem_wdata, e.data);
    chk("fwd_wreg", {31'd0, fwd_wreg}, {31'd0, (q.size() > 0) && e.wreg});
    chk("fwd_wd", {27'd0, fwd_wd}, {27'd0, e.wd});
    chk("fwd_wdata", fwd_wdata, e.data);
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("xfer_cnt", xfer_cnt, m_xfer);
`endif
    $display("cyc rn=%0b fl=%0b v=%0b wd=%0d d=%h mr=%0b -> mv=%0b wd=%0d d=%h rdy=%0b",
             rn, fl, v, wd, d, mr, mem_valid, mem_wd, mem_wdata, ex_ready);
  endtask

  initial begin
    m_stall = 0; m_xfer = 0;
    // Reset held with valid input: nothing captured.
    for (int i = 0; i < 3; i++) step(1, 5'd7, 1, 32'hDEADBEEF, 1, 0, 0);
    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 1, 32'h11 * i, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    // Stall fills skid; third push is refused.
    step(1, 5'd1, 1, 32'hA, 0, 1, 0);
    step(1, 5'd2, 1, 32'hB, 0, 1, 0);
    step(1, 5'd3, 1, 32'hD, 0, 1, 0);
    chk("skid_full_ready", {31'd0, ex_ready}, 32'd0);
    chk("skid_hold_A", mem_wdata, 32'hA);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("pop_to_B", mem_wdata, 32'hB);
    step(0, 0, 0, 0, 1, 1, 0);
    // Forwarding.
    step(1, 5'd5, 1, 32'h1234, 0, 1, 0);
    chk("fwd_wd_5", {27'd0, fwd_wd}, 32'd5);
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 5'd6, 0, 32'h5678, 1, 1, 0);
    chk("fwd_wreg_0", {31'd0, fwd_wreg}, 32'd0);
    // ex_valid=0 with wreg=1 is ignored.
    step(0, 5'd9, 1, 32'h99, 1, 1, 0);
    // Flush mid-stall with a new input.
    step(1, 5'd1, 1, 32'hA, 0, 1, 0);
    step(1, 5'd2, 1, 32'hB, 0, 1, 0);
    step(1, 5'd3, 1, 32'hC, 0, 1, 1);
    chk("flush_ready", {31'd0, ex_ready}, 32'd1);
    step(0, 0, 0, 0, 1, 1, 0);
    // Reset mid-stall.
    step(1, 5'd1, 1, 32'hE1, 0, 1, 0);
    step(1, 5'd2, 1, 32'hE2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Random traffic with occasional flush/reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
